// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Port index: 0 = CPU load/store unit, 1 = debug/DMA loader.
    typedef logic port_idx_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating event counter; holds at all-ones once full.
module dmem_arb_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of data_memory with bounded bursts.
// Define DMEM_ARB_STATS_EN to add grant/stall statistics counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]           stat_gnt0,
    output logic [31:0]           stat_gnt1,
    output logic [31:0]           stat_stall,
`endif
    input  logic [DATA_WIDTH-1:0] mem_data
);

    localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_next;
    port_idx_t        last_owner, last_next;
    logic [CNT_W-1:0] burst_cnt, cnt_next;
    logic             grant;
    port_idx_t        win;
    port_idx_t        own;
    logic             own_req, oth_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_next;
            last_owner <= last_next;
            burst_cnt  <= cnt_next;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        last_next  = last_owner;
        cnt_next   = burst_cnt;
        grant      = 1'b0;
        win        = 1'b0;
        own        = (state == OWN1);
        own_req    = own ? m1_req : m0_req;
        oth_req    = own ? m0_req : m1_req;
        unique case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant      = 1'b1;
                    win        = (m0_req && m1_req) ? ~last_owner : m1_req;
                    state_next = win ? OWN1 : OWN0;
                    cnt_next   = CNT_W'(1);
                end
            end
            OWN0, OWN1: begin
                if (own_req && ((burst_cnt < BURST_MAX) || !oth_req)) begin
                    grant = 1'b1;
                    win   = own;
                    if (burst_cnt < BURST_MAX) cnt_next = burst_cnt + CNT_W'(1);
                end else if (oth_req) begin
                    grant      = 1'b1;
                    win        = ~own;
                    state_next = own ? OWN0 : OWN1;
                    cnt_next   = CNT_W'(1);
                    last_next  = own;
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    last_next  = own;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grants are gated by rst_n so an asserted reset silences the memory at once.
    always_comb begin
        m0_gnt         = rst_n && grant && (win == 1'b0);
        m1_gnt         = rst_n && grant && (win == 1'b1);
        mem_write_en   = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (rst_n && grant && (win == 1'b0)) begin
            mem_write_en   = m0_we;
            mem_addr       = m0_addr;
            mem_write_data = m0_wdata;
        end else if (rst_n && grant && (win == 1'b1)) begin
            mem_write_en   = m1_we;
            mem_addr       = m1_addr;
            mem_write_data = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) m0_rdata <= mem_data;
            if (m1_gnt && !m1_we) m1_rdata <= mem_data;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic stall;
    assign stall = (m0_req && !m0_gnt) || (m1_req && !m1_gnt);

    dmem_arb_sat_counter #(.WIDTH(32)) u_stat_gnt0 (
        .clk(clk), .rst_n(rst_n), .inc(m0_gnt), .count(stat_gnt0)
    );
    dmem_arb_sat_counter #(.WIDTH(32)) u_stat_gnt1 (
        .clk(clk), .rst_n(rst_n), .inc(m1_gnt), .count(stat_gnt1)
    );
    dmem_arb_sat_counter #(.WIDTH(32)) u_stat_stall (
        .clk(clk), .rst_n(rst_n), .inc(stall), .count(stat_stall)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data_memory model.
// Statistics checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_data;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_gnt0, stat_gnt1, stat_stall;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
`ifdef DMEM_ARB_STATS_EN
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_stall(stat_stall),
`endif
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // data_memory model: synchronous write, combinational read
    assign mem_data = mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[3:0]] <= mem_write_data;
    end

    // Scoreboard monitor: pops an expected word for every rvalid pulse.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (m0_rvalid) begin
                total++;
                if (exp0.size() == 0) begin
                    bad++;
                    $display("FAIL rdata0_extra: m0_rvalid with rdata=%0h, no read expected", m0_rdata);
                end else begin
                    e = exp0.pop_front();
                    if (m0_rdata !== e) begin
                        bad++;
                        $display("FAIL rdata0: got %0h want %0h", m0_rdata, e);
                    end
                end
            end
            if (m1_rvalid) begin
                total++;
                if (exp1.size() == 0) begin
                    bad++;
                    $display("FAIL rdata1_extra: m1_rvalid with rdata=%0h, no read expected", m1_rdata);
                end else begin
                    e = exp1.pop_front();
                    if (m1_rdata !== e) begin
                        bad++;
                        $display("FAIL rdata1: got %0h want %0h", m1_rdata, e);
                    end
                end
            end
            total++;
            if ((m0_gnt && m1_gnt) || (m0_gnt && !m0_req) || (m1_gnt && !m1_req)) begin
                bad++;
                $display("FAIL gnt_legal: gnt=%b%b req=%b%b, want at most one gnt and only with req",
                         m0_gnt, m1_gnt, m0_req, m1_req);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd1; m0_wdata = 32'd5;
        #2;
        total++;
        if ({m0_gnt, m1_gnt, mem_write_en, m0_rvalid, m1_rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: gnt/we/rvalid=%b want 00000",
                     {m0_gnt, m1_gnt, mem_write_en, m0_rvalid, m1_rvalid});
        end
        total++;
        if ({m0_rdata, m1_rdata, mem_addr} !== 96'b0) begin
            bad++;
            $display("FAIL reset_data: rdata0=%0h rdata1=%0h mem_addr=%0h want 0",
                     m0_rdata, m1_rdata, mem_addr);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 5; i++) begin
            m0_req = 1'b1; m0_we = 1'b1; m0_addr = i; m0_wdata = 10 + i;
            #3;
            total++;
            if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b101 || mem_addr !== i || mem_write_data !== 10 + i) begin
                bad++;
                $display("FAIL write_burst[%0d]: gnt=%b%b we=%b addr=%0h data=%0h want 101 %0h %0h",
                         i, m0_gnt, m1_gnt, mem_write_en, mem_addr, mem_write_data, i, 10 + i);
            end
            ref_mem[i] = 10 + i;
            step();
        end
        idle_inputs();
        #3;
        total++;
        if (mem_write_en !== 1'b0) begin
            bad++;
            $display("FAIL write_stop: mem_write_en=%b want 0", mem_write_en);
        end
        step();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd3;
        #3;
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL read3_gnt: m0_gnt=%b want 1", m0_gnt);
        end
        exp0.push_back(ref_mem[3]);
        step();
        idle_inputs();
        total++;
        if (m0_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL read3_rvalid: m0_rvalid=%b want 1", m0_rvalid);
        end
        step();
        total++;
        if (m0_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL read3_pulse: m0_rvalid=%b want 0", m0_rvalid);
        end
    endtask

    task automatic test_round_robin();
        int winner;
        apply_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd4;
        for (int c = 0; c < 10; c++) begin
            winner = (c / 4) % 2;
            #3;
            total++;
            if ({m0_gnt, m1_gnt} !== ((winner == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_seq[%0d]: gnt=%b%b want port %0d", c, m0_gnt, m1_gnt, winner);
            end
            if (winner == 0) exp0.push_back(ref_mem[1]);
            else             exp1.push_back(ref_mem[4]);
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_tie_read_write();
        apply_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd2;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd2; m1_wdata = 32'd99;
        #3;
        total++;
        if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b100 || mem_addr !== 32'd2) begin
            bad++;
            $display("FAIL tie_first: gnt=%b%b we=%b addr=%0h want 100 2",
                     m0_gnt, m1_gnt, mem_write_en, mem_addr);
        end
        exp0.push_back(ref_mem[2]);
        step();
        m0_req = 1'b0;
        #3;
        total++;
        if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b011 || mem_write_data !== 32'd99) begin
            bad++;
            $display("FAIL tie_second: gnt=%b%b we=%b data=%0h want 011 63",
                     m0_gnt, m1_gnt, mem_write_en, mem_write_data);
        end
        ref_mem[2] = 32'd99;
        step();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd2;
        #3;
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL tie_reread_gnt: gnt=%b%b want 10", m0_gnt, m1_gnt);
        end
        exp0.push_back(ref_mem[2]);
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd3;
        #3;
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            bad++;
            $display("FAIL midrst_start: gnt=%b%b want 01", m0_gnt, m1_gnt);
        end
        exp1.push_back(ref_mem[3]);
        step();
        step();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd6; m0_wdata = 32'd66;
        total++;
        if ({m0_gnt, m1_gnt, m1_rvalid} !== 3'b011) begin
            bad++;
            $display("FAIL midrst_burst: gnt=%b%b rvalid1=%b want 01 1", m0_gnt, m1_gnt, m1_rvalid);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en} !== 5'b0 || m1_rdata !== 32'd0) begin
            bad++;
            $display("FAIL midrst_async: gnt=%b%b rvalid=%b%b we=%b rdata1=%0h want all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en, m1_rdata);
        end
        #4 rst_n = 1'b1;
        #1;
        total++;
        if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b101 || mem_addr !== 32'd6) begin
            bad++;
            $display("FAIL midrst_tie: gnt=%b%b we=%b addr=%0h want 101 6",
                     m0_gnt, m1_gnt, mem_write_en, mem_addr);
        end
        ref_mem[6] = 32'd66;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_single_m1_read();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd6;
        #3;
        total++;
        if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b010) begin
            bad++;
            $display("FAIL m1_read_gnt: gnt=%b%b we=%b want 010", m0_gnt, m1_gnt, mem_write_en);
        end
        exp1.push_back(ref_mem[6]);
        step();
        idle_inputs();
        total++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01) begin
            bad++;
            $display("FAIL m1_read_rvalid: rvalid=%b%b want 01", m0_rvalid, m1_rvalid);
        end
        step();
        total++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL m1_read_pulse: rvalid=%b%b want 00", m0_rvalid, m1_rvalid);
        end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) exp0.push_back(ref_mem[0]);
            else       exp1.push_back(ref_mem[0]);
            step();
        end
        idle_inputs();
        #3;
        total++;
        if (stat_gnt0 !== 32'd4 || stat_gnt1 !== 32'd4 || stat_stall !== 32'd8) begin
            bad++;
            $display("FAIL stats: gnt0=%0d gnt1=%0d stall=%0d want 4 4 8",
                     stat_gnt0, stat_gnt1, stat_stall);
        end
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write_burst();
        test_round_robin();
        test_tie_read_write();
        test_reset_mid_burst();
        test_single_m1_read();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        step();
        step();
        total++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            bad++;
            $display("FAIL drain: pending reads port0=%0d port1=%0d want 0 0", exp0.size(), exp1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port `data_memory` (synchronous write, combinational read) between the CPU load/store unit (port 0) and a debug/DMA loader (port 1). It sits directly in front of `data_memory`, grants at most one access per cycle with bounded-burst round-robin fairness, and returns registered read data with a valid pulse. It sequences all accesses to `data_memory`, so the memory never sees two masters.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, address width (word address, passed through unchanged)
- MAX_BURST, 4, maximum consecutive grants to one port while the other port waits (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_WIDTH  access address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_gnt / m1_gnt  out  1  combinational grant; access completes at the next rising edge
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse, read data valid
- m0_rdata / m1_rdata  out  DATA_WIDTH  registered read data, held until next read on that port
- mem_write_en  out  1  to data_memory write_en
- mem_addr  out  ADDR_WIDTH  to data_memory addr
- mem_write_data  out  DATA_WIDTH  to data_memory write_data
- mem_data  in  DATA_WIDTH  from data_memory data

## Operation
- FSM states: IDLE, OWN0, OWN1; plus last_owner bit and burst counter burst_cnt (width clog2(MAX_BURST)+1).
- IDLE: only one port requesting → grant it. Both requesting → grant the port ≠ last_owner. Next state is OWNx for the granted port, burst_cnt=1.
- OWNx: if mx_req and (burst_cnt < MAX_BURST or other port not requesting) → grant x, burst_cnt increments, saturating at MAX_BURST. Else if other port requests → grant other, go to OWNother, burst_cnt=1, last_owner=x. Else → no grant, go to IDLE, last_owner=x.
- Exactly one gnt or none is high in any cycle; a gnt requires the matching req.
- Memory drive: when a port is granted, mem_addr/mem_write_data follow that port and mem_write_en = its we. With no grant, all mem_* outputs are 0.
- Read: on the granted edge mem_data is captured into that port's rdata; rvalid pulses for the following cycle.
- Write: committed by data_memory on the granted edge; no rvalid.
- Requester may change addr/we/wdata only after the edge where gnt was sampled high.

## Timing
- Grant latency: 0 cycles (same cycle as req when the port wins). Read latency: rvalid one cycle after the grant edge.
- Back-to-back: one access per cycle sustained; alternating ports give 1 access/cycle with no bubbles.
- Worst-case wait for a requesting port: MAX_BURST cycles.
- Reset values: state IDLE, last_owner=1 (port 0 wins the first tie), burst_cnt=0, rvalid=0, rdata=0, gnt=0. mem_write_en is gated combinationally with rst_n, so no write occurs while reset is asserted.
- Reset asserted mid-burst: rvalid clears immediately, and the pending access is dropped; the requester must re-request.
- req dropped in the same cycle as the grant would occur: no grant, no memory access.

## Configuration
- DMEM_ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1 and stat_stall (32 bits each, reset 0, saturating at all-ones). stat_gnt0/stat_gnt1 count the grant edges for each port. stat_stall counts cycles in which any req is high without its gnt.
- DMEM_ARB_STATS_EN undefined: these ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, OWN0, OWN1), port index typedef, default DATA_WIDTH/ADDR_WIDTH constants.
- Sub-module dmem_arb_sat_counter: parameterized-width saturating counter with clk/rst_n/inc. It is instantiated three times, under DMEM_ARB_STATS_EN only.

## Test plan
- Port 0 writes 10..14 to addresses 0..4; port 1 idle → m0_gnt high every cycle and mem_write_en high for 5 edges. A later port-0 read of address 3 gives m0_rvalid one cycle after the grant with m0_rdata=13.
- Both ports hold req continuously with MAX_BURST=4 from reset → grant sequence 0,0,0,0,1,1,1,1,0,…
- Port 0 reads address 2 (value 12) while port 1 writes 99 to address 2, both requesting in IDLE from reset → port 0 granted first with rdata=12, then port 1's write. A subsequent read returns 99.
- rst_n pulled low for half a cycle during a port-1 burst → all gnt/rvalid go to 0 immediately and mem_write_en=0. After release, the first tie grants port 0.
- Single port 1 read with no contention → m1_gnt same cycle, single m1_rvalid pulse, m0_rvalid stays 0.
- With DMEM_ARB_STATS_EN, run 8 contended cycles (MAX_BURST=4) → stat_gnt0=4, stat_gnt1=4, stat_stall=8.
